// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and port identifiers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int PORT_CPU = 0;
  localparam int PORT_LD  = 1;

  function automatic logic [1:0] port_sel(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, combinational from req; pointer toggles only when a contended pick is taken.
// A single requester always wins; pointer resets to prefer port 0.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       pick,
  output logic       pick_vld
);

  logic ptr;

  assign pick_vld = |req;
  assign pick     = (req == 2'b11) ? ptr : req[1];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr <= 1'b0;
    end else if (take && req == 2'b11) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one memory port between CPU (port 0) and loader (port 1); gnt at t+1, rvalid MEM_LAT cycles after gnt.
// One transaction in flight, requesters hold req until gnt; MEM_ARB_PERF_EN adds saturating grant/conflict counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1,
  output logic [15:0]       conflict_cnt
`endif
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  state_t              state, state_nxt;
  logic                cmd_port;
  logic                cmd_we;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    cnt;
  logic                pick, pick_vld, take;
  logic                issue, rd_done;

  rr_arb2 u_rr (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .take     (take),
    .pick     (pick),
    .pick_vld (pick_vld)
  );

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          take      = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = cmd_we ? ST_IDLE : ST_WAIT;
      ST_WAIT:  if (cnt == CNT_W'(1)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cmd_port  <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        cmd_port  <= pick;
        cmd_we    <= we[pick];
        cmd_addr  <= pick ? addr1 : addr0;
        cmd_wdata <= pick ? wdata1 : wdata0;
      end
      if (state == ST_ISSUE) begin
        cnt <= CNT_W'(MEM_LAT);
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 1'b1;
      end
      if (rd_done) rdata_q <= mem_rdata;
    end
  end

  // Strobes are qualified by reset_n so a reset landing on the data cycle drops the read.
  assign issue     = reset_n && (state == ST_ISSUE);
  assign rd_done   = reset_n && (state == ST_WAIT) && (cnt == CNT_W'(1));
  assign gnt       = issue ? port_sel(cmd_port) : 2'b00;
  assign rvalid    = rd_done ? port_sel(cmd_port) : 2'b00;
  assign mem_read  = issue && !cmd_we;
  assign mem_write = issue && cmd_we;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;
  assign rdata     = rd_done ? mem_rdata : rdata_q;

`ifdef MEM_ARB_PERF_EN
  localparam logic [15:0] SAT = 16'hFFFF;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      gnt_cnt0     <= '0;
      gnt_cnt1     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt[PORT_CPU] && gnt_cnt0 != SAT) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (gnt[PORT_LD] && gnt_cnt1 != SAT) gnt_cnt1 <= gnt_cnt1 + 1'b1;
      if (state == ST_IDLE && req == 2'b11 && conflict_cnt != SAT)
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiters (MEM_LAT=1 and MEM_LAT=3) with behavioural memories;
// expected gnt/rvalid events are queued at stimulus time and popped by a negedge monitor.
module tb_mem_port_arbiter;

  typedef struct {
    bit          rv;
    bit          port;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  logic preload;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // DUT A, MEM_LAT = 1
  logic [1:0]  a_req, a_we, a_gnt, a_rvalid;
  logic [15:0] a_addr0, a_addr1, a_wdata0, a_wdata1, a_rdata;
  logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_mem_read, a_mem_write;
  // DUT B, MEM_LAT = 3
  logic [1:0]  b_req, b_we, b_gnt, b_rvalid;
  logic [15:0] b_addr0, b_addr1, b_wdata0, b_wdata1, b_rdata;
  logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_mem_read, b_mem_write;
`ifdef MEM_ARB_PERF_EN
  logic [15:0] a_gc0, a_gc1, a_cc, b_gc0, b_gc1, b_cc;
`endif

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut (
    .clock(clock), .reset_n(reset_n), .req(a_req), .we(a_we),
    .addr0(a_addr0), .addr1(a_addr1), .wdata0(a_wdata0), .wdata1(a_wdata1),
    .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_read(a_mem_read),
    .mem_write(a_mem_write), .mem_rdata(a_mem_rdata)
`ifdef MEM_ARB_PERF_EN
    , .gnt_cnt0(a_gc0), .gnt_cnt1(a_gc1), .conflict_cnt(a_cc)
`endif
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) u_lat3 (
    .clock(clock), .reset_n(reset_n), .req(b_req), .we(b_we),
    .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
    .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .mem_rdata(b_mem_rdata)
`ifdef MEM_ARB_PERF_EN
    , .gnt_cnt0(b_gc0), .gnt_cnt1(b_gc1), .conflict_cnt(b_cc)
`endif
  );

  // Behavioural memories: read data appears MEM_LAT edges after the strobe cycle.
  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  logic [15:0] a_rd, b_p0, b_p1, b_p2;

  always @(posedge clock) begin
    if (preload) begin
      mem_a[8'h10] <= 16'hBEEF;
      mem_a[8'h40] <= 16'h0000;
    end else if (a_mem_write) begin
      mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
    end
    a_rd <= a_mem_read ? mem_a[a_mem_addr[7:0]] : 16'h0000;
  end
  assign a_mem_rdata = a_rd;

  always @(posedge clock) begin
    if (preload) begin
      mem_b[8'h10] <= 16'hBEEF;
      mem_b[8'h20] <= 16'h5A5A;
    end else if (b_mem_write) begin
      mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
    end
    b_p0 <= b_mem_read ? mem_b[b_mem_addr[7:0]] : 16'h0000;
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_mem_rdata = b_p2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input bit rv, input bit port, input bit wr,
                              input logic [15:0] addr, input logic [15:0] data, input int c);
    exp_t e;
    e.rv = rv; e.port = port; e.wr = wr; e.addr = addr; e.data = data; e.cyc = c;
    return e;
  endfunction

  // Monitor: every gnt/rvalid pulse must match the head of its scoreboard queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (a_gnt != 2'b00) begin
        if (qa.size() == 0) check("a_unexpected_gnt", 32'(a_gnt), 32'd0);
        else begin
          e = qa.pop_front();
          check("a_kind_gnt", 32'(e.rv), 32'd0);
          check("a_gnt", 32'(a_gnt), e.port ? 32'd2 : 32'd1);
          check("a_gnt_cycle", 32'(cyc), 32'(e.cyc));
          check("a_mem_write", 32'(a_mem_write), 32'(e.wr));
          check("a_mem_read", 32'(a_mem_read), 32'(!e.wr));
          check("a_mem_addr", 32'(a_mem_addr), 32'(e.addr));
          if (e.wr) check("a_mem_wdata", 32'(a_mem_wdata), 32'(e.data));
        end
      end
      if (a_rvalid != 2'b00) begin
        if (qa.size() == 0) check("a_unexpected_rvalid", 32'(a_rvalid), 32'd0);
        else begin
          e = qa.pop_front();
          check("a_kind_rvalid", 32'(e.rv), 32'd1);
          check("a_rvalid", 32'(a_rvalid), e.port ? 32'd2 : 32'd1);
          check("a_rvalid_cycle", 32'(cyc), 32'(e.cyc));
          check("a_rdata", 32'(a_rdata), 32'(e.data));
        end
      end
      if (b_gnt != 2'b00) begin
        if (qb.size() == 0) check("b_unexpected_gnt", 32'(b_gnt), 32'd0);
        else begin
          e = qb.pop_front();
          check("b_kind_gnt", 32'(e.rv), 32'd0);
          check("b_gnt", 32'(b_gnt), e.port ? 32'd2 : 32'd1);
          check("b_gnt_cycle", 32'(cyc), 32'(e.cyc));
          check("b_mem_addr", 32'(b_mem_addr), 32'(e.addr));
        end
      end
      if (b_rvalid != 2'b00) begin
        if (qb.size() == 0) check("b_unexpected_rvalid", 32'(b_rvalid), 32'd0);
        else begin
          e = qb.pop_front();
          check("b_kind_rvalid", 32'(e.rv), 32'd1);
          check("b_rvalid", 32'(b_rvalid), e.port ? 32'd2 : 32'd1);
          check("b_rvalid_cycle", 32'(cyc), 32'(e.cyc));
          check("b_rdata", 32'(b_rdata), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Single transaction on DUT A; expected events are queued at the cycle req goes up.
  task automatic req_a(input bit port, input bit wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] rexp);
    int n;
    @(posedge clock); #1;
    a_req[port] = 1'b1;
    a_we[port]  = wr;
    if (port) begin a_addr1 = addr; a_wdata1 = wdata; end
    else      begin a_addr0 = addr; a_wdata0 = wdata; end
    qa.push_back(mk(1'b0, port, wr, addr, wdata, cyc + 1));
    if (!wr) qa.push_back(mk(1'b1, port, 1'b0, addr, rexp, cyc + 2));
    n = 0;
    @(negedge clock);
    while (a_gnt[port] !== 1'b1 && n < 30) begin
      @(negedge clock);
      n++;
    end
    if (n == 30) check("a_gnt_timeout", 32'd1, 32'd0);
    @(posedge clock); #1;
    a_req[port] = 1'b0;
    repeat (3) @(posedge clock);
  endtask

  task automatic do_reset(input int n);
    @(posedge clock); #1;
    reset_n = 1'b0;
    repeat (n) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int c;
    reset_n = 1'b0; preload = 1'b1;
    a_req = 2'b00; a_we = 2'b00; a_addr0 = 16'h0; a_addr1 = 16'h0; a_wdata0 = 16'h0; a_wdata1 = 16'h0;
    b_req = 2'b00; b_we = 2'b00; b_addr0 = 16'h0; b_addr1 = 16'h0; b_wdata0 = 16'h0; b_wdata1 = 16'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_gnt", 32'(a_gnt), 32'd0);
    check("reset_rvalid", 32'(a_rvalid), 32'd0);
    check("reset_strobes", 32'({a_mem_read, a_mem_write}), 32'd0);
    check("reset_mem_addr", 32'(a_mem_addr), 32'd0);
    check("reset_mem_wdata", 32'(a_mem_wdata), 32'd0);
    check("reset_rdata", 32'(a_rdata), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1; preload = 1'b0;

    // CPU read, loader write, then CPU read-back of the written word.
    req_a(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
    @(negedge clock);
    check("a_rdata_hold", 32'(a_rdata), 32'h0000BEEF);
    req_a(1'b1, 1'b1, 16'h0040, 16'h1234, 16'h0000);
    req_a(1'b0, 1'b0, 16'h0040, 16'h0000, 16'h1234);

    // Contention from reset: five alternating grants starting at port 0.
    do_reset(2);
    @(posedge clock); #1;
    c = cyc;
    a_we = 2'b00; a_addr0 = 16'h0010; a_addr1 = 16'h0040; a_req = 2'b11;
    for (int k = 0; k < 5; k++) begin
      qa.push_back(mk(1'b0, k[0], 1'b0, k[0] ? 16'h0040 : 16'h0010, 16'h0, c + 1 + 3 * k));
      qa.push_back(mk(1'b1, k[0], 1'b0, 16'h0, k[0] ? 16'h1234 : 16'hBEEF, c + 2 + 3 * k));
    end
    repeat (13) @(posedge clock);
    #1 a_req = 2'b00;
    repeat (4) @(posedge clock);
`ifdef MEM_ARB_PERF_EN
    @(negedge clock);
    check("perf_gnt_cnt0", 32'(a_gc0), 32'd3);
    check("perf_gnt_cnt1", 32'(a_gc1), 32'd2);
    check("perf_conflict_cnt", 32'(a_cc), 32'd5);
`endif

    // Reset during WAIT: no rvalid, outputs cleared, pointer back to port 0.
    @(posedge clock); #1;
    c = cyc;
    a_addr0 = 16'h0010; a_req = 2'b01;
    qa.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, c + 1));
    @(posedge clock); #1;
    @(posedge clock); #1;
    a_req = 2'b00;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("midrd_gnt", 32'(a_gnt), 32'd0);
    check("midrd_rvalid", 32'(a_rvalid), 32'd0);
    check("midrd_mem_addr", 32'(a_mem_addr), 32'd0);
    check("midrd_rdata", 32'(a_rdata), 32'd0);
    @(posedge clock); #1;
    c = cyc;
    a_addr0 = 16'h0010; a_addr1 = 16'h0040; a_req = 2'b11;
    qa.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, c + 1));
    qa.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0, 16'hBEEF, c + 2));
    @(posedge clock); #1;
    @(posedge clock); #1;
    a_req = 2'b00;
    repeat (4) @(posedge clock);

    // MEM_LAT=3: read returns 3 cycles after gnt; loader raised during WAIT is served after.
    @(posedge clock); #1;
    c = cyc;
    b_addr0 = 16'h0010; b_req = 2'b01;
    qb.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, c + 1));
    qb.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0, 16'hBEEF, c + 4));
    @(posedge clock); #1;
    @(posedge clock); #1;
    b_req = 2'b10; b_addr1 = 16'h0020;
    qb.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, c + 6));
    qb.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0, 16'h5A5A, c + 9));
    repeat (5) @(posedge clock);
    #1 b_req = 2'b00;
    repeat (6) @(posedge clock);
    @(negedge clock);
    check("b_rdata_hold", 32'(b_rdata), 32'h00005A5A);
    check("a_queue_drained", 32'(qa.size()), 32'd0);
    check("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
